// File: rtl/ctrl_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : ctrl_pipe
//  Description : ID/EX, EX/MEM and MEM/WB control registers for the Decode
//                control bundle, with stall/flush bubble insertion. Optional
//                bubble counter is built when CTRL_PERF_EN is defined.
//  Revision    : 1.0 - initial release
// ============================================================================
module ctrl_pipe #(
    parameter int CTRL_W = 9,
    parameter int PERF_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [CTRL_W-1:0] id_ctrl,
    input  logic              id_valid,
    input  logic              stall,
    input  logic              flush,
    output logic              ex_valid,
    output logic              ex_reg_dst,
    output logic              ex_alu_src,
    output logic [1:0]        ex_alu_op,
    output logic              mem_valid,
    output logic              mem_read,
    output logic              mem_write,
    output logic              mem_branch,
    output logic              wb_valid,
    output logic              wb_mem_to_reg,
    output logic              wb_reg_write
`ifdef CTRL_PERF_EN
    ,
    output logic [PERF_W-1:0] bubble_cnt
`endif
);

    // Bit positions inside the Decode control word
    localparam int BIT_REG_DST    = 8;
    localparam int BIT_ALU_SRC    = 7;
    localparam int BIT_MEM_TO_REG = 6;
    localparam int BIT_REG_WRITE  = 5;
    localparam int BIT_MEM_READ   = 4;
    localparam int BIT_MEM_WRITE  = 3;
    localparam int BIT_BRANCH     = 2;
    localparam int BIT_ALU_OP_HI  = 1;
    localparam int BIT_ALU_OP_LO  = 0;

    // MEM-stage word layout: {MemtoReg, RegWrite, MemRead, MemWrite, Branch}
    localparam int MEM_W = 5;
    localparam int WB_W  = 2;

    logic              ex_valid_q,  ex_valid_d;
    logic [CTRL_W-1:0] ex_ctrl_q,   ex_ctrl_d;
    logic              mem_valid_q, mem_valid_d;
    logic [MEM_W-1:0]  mem_ctrl_q,  mem_ctrl_d;
    logic              wb_valid_q,  wb_valid_d;
    logic [WB_W-1:0]   wb_ctrl_q,   wb_ctrl_d;
    logic              ex_load;

    // Flush dominates stall; either one, or an idle slot, loads a bubble into EX.
    assign ex_load = id_valid & ~stall & ~flush;

    always_comb begin
        ex_valid_d  = ex_load;
        ex_ctrl_d   = ex_load ? id_ctrl : '0;

        mem_valid_d = 1'b0;
        mem_ctrl_d  = '0;
        if (!flush) begin
            mem_valid_d = ex_valid_q;
            mem_ctrl_d  = {ex_ctrl_q[BIT_MEM_TO_REG], ex_ctrl_q[BIT_REG_WRITE],
                           ex_ctrl_q[BIT_MEM_READ],   ex_ctrl_q[BIT_MEM_WRITE],
                           ex_ctrl_q[BIT_BRANCH]};
        end

        // WB is never squashed: whatever sits in MEM has already committed.
        wb_valid_d  = mem_valid_q;
        wb_ctrl_d   = mem_ctrl_q[MEM_W-1 -: WB_W];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ex_valid_q  <= 1'b0;
            ex_ctrl_q   <= '0;
            mem_valid_q <= 1'b0;
            mem_ctrl_q  <= '0;
            wb_valid_q  <= 1'b0;
            wb_ctrl_q   <= '0;
        end else begin
            ex_valid_q  <= ex_valid_d;
            ex_ctrl_q   <= ex_ctrl_d;
            mem_valid_q <= mem_valid_d;
            mem_ctrl_q  <= mem_ctrl_d;
            wb_valid_q  <= wb_valid_d;
            wb_ctrl_q   <= wb_ctrl_d;
        end
    end

    assign ex_valid      = ex_valid_q;
    assign ex_reg_dst    = ex_ctrl_q[BIT_REG_DST];
    assign ex_alu_src    = ex_ctrl_q[BIT_ALU_SRC];
    assign ex_alu_op     = {ex_ctrl_q[BIT_ALU_OP_HI], ex_ctrl_q[BIT_ALU_OP_LO]};

    assign mem_valid     = mem_valid_q;
    assign mem_read      = mem_ctrl_q[2];
    assign mem_write     = mem_ctrl_q[1];
    assign mem_branch    = mem_ctrl_q[0];

    assign wb_valid      = wb_valid_q;
    assign wb_mem_to_reg = wb_ctrl_q[1];
    assign wb_reg_write  = wb_ctrl_q[0];

`ifdef CTRL_PERF_EN
    logic [PERF_W-1:0] bubble_cnt_q, bubble_cnt_d;

    // Saturating count of edges on which EX took a bubble.
    always_comb begin
        bubble_cnt_d = bubble_cnt_q;
        if (!ex_load && !(&bubble_cnt_q)) begin
            bubble_cnt_d = bubble_cnt_q + PERF_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bubble_cnt_q <= '0;
        end else begin
            bubble_cnt_q <= bubble_cnt_d;
        end
    end

    assign bubble_cnt = bubble_cnt_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_ctrl_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ctrl_pipe
//  Description : Directed self-checking bench for ctrl_pipe (stream, stall,
//                flush, reset, perf counter when CTRL_PERF_EN is defined).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ctrl_pipe;

    localparam int PERF_W = 16;

    // Decode control words
    localparam logic [8:0] W_R   = 9'b110100010;
    localparam logic [8:0] W_LW  = 9'b011110000;
    localparam logic [8:0] W_SW  = 9'b010001000;
    localparam logic [8:0] W_BEQ = 9'b000000101;
    localparam logic [8:0] W_NOP = 9'b000000000;

    // Expected stage views: ex={valid,reg_dst,alu_src,alu_op}, mem={valid,read,write,branch},
    // wb={valid,mem_to_reg,reg_write}
    localparam logic [4:0] EX_R   = 5'b11110, EX_LW  = 5'b10100, EX_SW = 5'b10100;
    localparam logic [4:0] EX_BEQ = 5'b10001, EX_NOP = 5'b10000, EX_B  = 5'b00000;
    localparam logic [3:0] MM_R   = 4'b1000,  MM_LW  = 4'b1100,  MM_SW = 4'b1010;
    localparam logic [3:0] MM_BEQ = 4'b1001,  MM_NOP = 4'b1000,  MM_B  = 4'b0000;
    localparam logic [2:0] WB_R   = 3'b101,   WB_LW  = 3'b111,   WB_SW = 3'b100;
    localparam logic [2:0] WB_BEQ = 3'b100,   WB_NOP = 3'b100,   WB_B  = 3'b000;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [8:0] id_ctrl;
    logic       id_valid, stall, flush;
    logic       ex_valid, ex_reg_dst, ex_alu_src;
    logic [1:0] ex_alu_op;
    logic       mem_valid, mem_read, mem_write, mem_branch;
    logic       wb_valid, wb_mem_to_reg, wb_reg_write;
`ifdef CTRL_PERF_EN
    logic [PERF_W-1:0] bubble_cnt;
`endif

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    ctrl_pipe #(.CTRL_W(9), .PERF_W(PERF_W)) u_dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .id_ctrl       (id_ctrl),
        .id_valid      (id_valid),
        .stall         (stall),
        .flush         (flush),
        .ex_valid      (ex_valid),
        .ex_reg_dst    (ex_reg_dst),
        .ex_alu_src    (ex_alu_src),
        .ex_alu_op     (ex_alu_op),
        .mem_valid     (mem_valid),
        .mem_read      (mem_read),
        .mem_write     (mem_write),
        .mem_branch    (mem_branch),
        .wb_valid      (wb_valid),
        .wb_mem_to_reg (wb_mem_to_reg),
        .wb_reg_write  (wb_reg_write)
`ifdef CTRL_PERF_EN
        ,
        .bubble_cnt    (bubble_cnt)
`endif
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one edge; sample 1ns after it, well before the next edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic rn, input logic v, input logic [8:0] w,
                         input logic st, input logic fl);
        rst_n    = rn;
        id_valid = v;
        id_ctrl  = w;
        stall    = st;
        flush    = fl;
    endtask

    task automatic check_stages(input string tag, input logic [4:0] ex_e,
                                input logic [3:0] mem_e, input logic [2:0] wb_e);
        check_eq({tag, ".ex"},  32'({ex_valid, ex_reg_dst, ex_alu_src, ex_alu_op}), 32'(ex_e));
        check_eq({tag, ".mem"}, 32'({mem_valid, mem_read, mem_write, mem_branch}), 32'(mem_e));
        check_eq({tag, ".wb"},  32'({wb_valid, wb_mem_to_reg, wb_reg_write}), 32'(wb_e));
    endtask

    initial begin
        // Reset held 2 clocks with a valid R word present
        drive(1'b0, 1'b1, W_R, 1'b0, 1'b0);
        step(); step();
        check_stages("reset", EX_B, MM_B, WB_B);
`ifdef CTRL_PERF_EN
        check_eq("reset.cnt", 32'(bubble_cnt), 32'd0);
`endif

        // Stream R, lw, sw, beq
        drive(1'b1, 1'b1, W_R, 1'b0, 1'b0);   step(); check_stages("s1", EX_R,   MM_B,   WB_B);
        drive(1'b1, 1'b1, W_LW, 1'b0, 1'b0);  step(); check_stages("s2", EX_LW,  MM_R,   WB_B);
        drive(1'b1, 1'b1, W_SW, 1'b0, 1'b0);  step(); check_stages("s3", EX_SW,  MM_LW,  WB_R);
        drive(1'b1, 1'b1, W_BEQ, 1'b0, 1'b0); step(); check_stages("s4", EX_BEQ, MM_SW,  WB_LW);
        drive(1'b1, 1'b0, W_R, 1'b0, 1'b0);   step(); check_stages("s5", EX_B,   MM_BEQ, WB_SW);
        step(); check_stages("s6", EX_B, MM_B, WB_BEQ);
        step(); check_stages("s7", EX_B, MM_B, WB_B);

        // Stall: lw then one stall cycle with R presented
        drive(1'b0, 1'b0, W_NOP, 1'b0, 1'b0); step();
        drive(1'b1, 1'b1, W_LW, 1'b0, 1'b0);  step(); check_stages("st1", EX_LW, MM_B,  WB_B);
        drive(1'b1, 1'b1, W_R, 1'b1, 1'b0);   step(); check_stages("st2", EX_B,  MM_LW, WB_B);
`ifdef CTRL_PERF_EN
        check_eq("stall.cnt", 32'(bubble_cnt), 32'd1);
`endif
        drive(1'b1, 1'b1, W_R, 1'b0, 1'b0);   step(); check_stages("st3", EX_R,  MM_B,  WB_LW);

        // Flush with sw in EX and beq in MEM
        drive(1'b1, 1'b1, W_BEQ, 1'b0, 1'b0); step(); check_stages("f1", EX_BEQ, MM_R,   WB_B);
        drive(1'b1, 1'b1, W_SW, 1'b0, 1'b0);  step(); check_stages("f2", EX_SW,  MM_BEQ, WB_R);
        drive(1'b1, 1'b1, W_R, 1'b0, 1'b1);   step(); check_stages("f3", EX_B,   MM_B,   WB_BEQ);
        drive(1'b1, 1'b1, W_R, 1'b0, 1'b0);   step(); check_stages("f4", EX_R,   MM_B,   WB_B);

        // Stall and flush together behave as flush
        drive(1'b1, 1'b1, W_BEQ, 1'b0, 1'b0); step(); check_stages("sf1", EX_BEQ, MM_R,   WB_B);
        drive(1'b1, 1'b1, W_SW, 1'b0, 1'b0);  step(); check_stages("sf2", EX_SW,  MM_BEQ, WB_R);
        drive(1'b1, 1'b1, W_R, 1'b1, 1'b1);   step(); check_stages("sf3", EX_B,   MM_B,   WB_BEQ);

        // Reset with three instructions in flight
        drive(1'b1, 1'b1, W_LW, 1'b0, 1'b0);  step(); check_stages("r1", EX_LW,  MM_B,   WB_B);
        drive(1'b1, 1'b1, W_SW, 1'b0, 1'b0);  step(); check_stages("r2", EX_SW,  MM_LW,  WB_B);
        drive(1'b1, 1'b1, W_BEQ, 1'b0, 1'b0); step(); check_stages("r3", EX_BEQ, MM_SW,  WB_LW);
        drive(1'b0, 1'b1, W_R, 1'b0, 1'b0);   step(); check_stages("r4", EX_B,   MM_B,   WB_B);
        drive(1'b1, 1'b1, W_R, 1'b0, 1'b0);   step(); check_stages("r5", EX_R,   MM_B,   WB_B);

        // All-zero word with id_valid=1 is a valid no-op
        drive(1'b1, 1'b1, W_NOP, 1'b0, 1'b0); step(); check_stages("n1", EX_NOP, MM_R,   WB_B);
        drive(1'b1, 1'b0, W_R, 1'b0, 1'b0);   step(); check_stages("n2", EX_B,   MM_NOP, WB_R);
        step(); check_stages("n3", EX_B, MM_B, WB_NOP);

`ifdef CTRL_PERF_EN
        // Counter saturation
        drive(1'b0, 1'b0, W_NOP, 1'b0, 1'b0); step();
        check_eq("perf.clr", 32'(bubble_cnt), 32'd0);
        drive(1'b1, 1'b1, W_R, 1'b1, 1'b0);
        for (int i = 0; i < (1 << PERF_W) + 3; i++) step();
        check_eq("perf.sat", 32'(bubble_cnt), 32'((1 << PERF_W) - 1));
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
